// File: rtl/control.sv
// Instruction decoder for a MIPS-style datapath: purely combinational mux,
// enable and ALU-operation controls from opcode/funct, gated by fetch/execute and reset.
module control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] instruction_opcode,
    input  logic [5:0] func_code,
    input  logic [4:0] special_branch_codes,
    input  logic       state,
    input  logic       B_link,
    output logic       RegDst,
    output logic       MemRead,
    output logic       MemtoReg,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic       R31,
    output logic       ShiftAmt,
    output logic       Add,
    output logic       Sub,
    output logic       Mul,
    output logic       Div,
    output logic       Unsigned,
    output logic       Or,
    output logic       And,
    output logic       Xor,
    output logic       SL,
    output logic       SR,
    output logic       Arithmetic,
    output logic       Boolean
);

    typedef struct packed {
        logic reg_dst, mem_read, mem_to_reg, mem_write, alu_src, reg_write, r31, shift_amt;
        logic add, sub, mul, div, is_unsigned, op_or, op_and, op_xor, sl, sr, arith, boolean;
    } ctrl_t;

    // Every REGIMM branch behaves identically, and clk only exists for interface symmetry.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, clk, special_branch_codes};

    ctrl_t dec;
    ctrl_t ctrl;
    logic  link;

    always_comb begin
        // NOTE: defaults first so every path assigns every field; no latches are inferred.
        dec  = '0;
        link = 1'b0;
        case (instruction_opcode)
            6'b000000: begin
                case (func_code)
                    6'b100001: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.add = 1'b1; dec.is_unsigned = 1'b1; end
                    6'b100011: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.sub = 1'b1; dec.is_unsigned = 1'b1; end
                    6'b100100: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.op_and = 1'b1; end
                    6'b100101: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.op_or = 1'b1; end
                    6'b100110: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.op_xor = 1'b1; end
                    6'b101010: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.sub = 1'b1; dec.boolean = 1'b1; end
                    6'b101011: begin
                        dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.sub = 1'b1;
                        dec.is_unsigned = 1'b1; dec.boolean = 1'b1;
                    end
                    6'b000000: begin
                        dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                        dec.shift_amt = 1'b1; dec.sl = 1'b1;
                    end
                    6'b000010: begin
                        dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                        dec.shift_amt = 1'b1; dec.sr = 1'b1;
                    end
                    6'b000011: begin
                        dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                        dec.shift_amt = 1'b1; dec.sr = 1'b1; dec.arith = 1'b1;
                    end
                    6'b000100: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.sl = 1'b1; end
                    6'b000110: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.sr = 1'b1; end
                    6'b000111: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.sr = 1'b1; dec.arith = 1'b1; end
                    6'b011000: dec.mul = 1'b1;
                    6'b011001: begin dec.mul = 1'b1; dec.is_unsigned = 1'b1; end
                    6'b011010: dec.div = 1'b1;
                    6'b011011: begin dec.div = 1'b1; dec.is_unsigned = 1'b1; end
                    6'b010000,
                    6'b010010: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; end
                    6'b001000: link = 1'b1;
                    6'b001001: begin dec.reg_dst = 1'b1; link = 1'b1; end
                    default: ;  // MTHI/MTLO and unlisted functs decode to all zeros
                endcase
            end
            6'b000001,
            6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
                dec.alu_src = 1'b1; dec.sub = 1'b1; link = 1'b1;
            end
            6'b000010, 6'b000011: link = 1'b1;
            6'b001001: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.add = 1'b1; dec.is_unsigned = 1'b1; end
            6'b001010: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.sub = 1'b1; dec.boolean = 1'b1; end
            6'b001011: begin
                dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.sub = 1'b1;
                dec.is_unsigned = 1'b1; dec.boolean = 1'b1;
            end
            6'b001100: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.op_and = 1'b1; end
            6'b001101: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.op_or = 1'b1; end
            6'b001110: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.op_xor = 1'b1; end
            6'b001111: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.sl = 1'b1; end
            6'b100011: begin
                dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.alu_src = 1'b1;
                dec.reg_write = 1'b1; dec.add = 1'b1;
            end
            6'b101011: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.add = 1'b1; end
            default: ;
        endcase

        // Branches and jumps write the link register only when the external link condition holds.
        if (link && B_link) begin
            dec.reg_write = 1'b1;
            dec.r31       = 1'b1;
        end

        ctrl = dec;
        if (!state) begin
            ctrl.reg_write = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.mem_read  = 1'b0;
        end
        if (reset) ctrl = '0;
    end

    assign {RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, R31, ShiftAmt,
            Add, Sub, Mul, Div, Unsigned, Or, And, Xor, SL, SR, Arithmetic, Boolean} = ctrl;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the control decoder: directed vector table, reset
// sequences, and randomized stimulus against a table-lookup reference model.
module tb_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] func;
    logic [4:0] sbc;
    logic       state;
    logic       b_link;

    logic reg_dst, mem_read, mem_to_reg, mem_write, alu_src, reg_write, r31, shift_amt;
    logic add, sub, mul, div, uns, op_or, op_and, op_xor, sl, sr, arith, boolean;
    logic [19:0] outs;

    // Bit order, MSB first: RegDst MemRead MemtoReg MemWrite ALUSrc RegWrite R31 ShiftAmt
    // Add Sub Mul Div Unsigned Or And Xor SL SR Arithmetic Boolean
    localparam logic [19:0] K_RD  = 20'h80000, K_MR  = 20'h40000, K_M2R = 20'h20000, K_MW  = 20'h10000;
    localparam logic [19:0] K_AS  = 20'h08000, K_RW  = 20'h04000, K_R31 = 20'h02000, K_SA  = 20'h01000;
    localparam logic [19:0] K_ADD = 20'h00800, K_SUB = 20'h00400, K_MUL = 20'h00200, K_DIV = 20'h00100;
    localparam logic [19:0] K_UNS = 20'h00080, K_OR  = 20'h00040, K_AND = 20'h00020, K_XOR = 20'h00010;
    localparam logic [19:0] K_SL  = 20'h00008, K_SR  = 20'h00004, K_ARI = 20'h00002, K_BOOL = 20'h00001;

    always #5 clk = ~clk;

    control dut (
        .clk(clk), .reset(reset), .instruction_opcode(opcode), .func_code(func),
        .special_branch_codes(sbc), .state(state), .B_link(b_link),
        .RegDst(reg_dst), .MemRead(mem_read), .MemtoReg(mem_to_reg), .MemWrite(mem_write),
        .ALUSrc(alu_src), .RegWrite(reg_write), .R31(r31), .ShiftAmt(shift_amt),
        .Add(add), .Sub(sub), .Mul(mul), .Div(div), .Unsigned(uns), .Or(op_or),
        .And(op_and), .Xor(op_xor), .SL(sl), .SR(sr), .Arithmetic(arith), .Boolean(boolean)
    );

    assign outs = {reg_dst, mem_read, mem_to_reg, mem_write, alu_src, reg_write, r31, shift_amt,
                   add, sub, mul, div, uns, op_or, op_and, op_xor, sl, sr, arith, boolean};

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [19:0] actual, input logic [19:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %05h expected %05h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic bl,
                         input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sb);
        reset = r; state = st; b_link = bl; opcode = op; func = fn; sbc = sb;
    endtask

    // Reference model: instruction -> control set tables, then the link and fetch rules.
    logic [19:0] rtype_map [logic [5:0]];
    logic [19:0] itype_map [logic [5:0]];

    function automatic logic [19:0] model(input logic r, input logic st, input logic bl,
                                          input logic [5:0] op, input logic [5:0] fn);
        logic [19:0] m;
        bit is_link;
        m = '0;
        is_link = 0;
        if (op == 6'd0) begin
            if (rtype_map.exists(fn)) m = rtype_map[fn];
            is_link = (fn == 6'b001000) || (fn == 6'b001001);
        end else begin
            if (itype_map.exists(op)) m = itype_map[op];
            is_link = (op >= 6'd1) && (op <= 6'd7);
        end
        if (is_link && bl) m |= K_RW | K_R31;
        if (!st) m &= ~(K_RW | K_MW | K_MR);
        if (r) m = '0;
        return m;
    endfunction

    typedef struct {
        string       name;
        logic        rst;
        logic        st;
        logic        bl;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sb;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic r, input logic st, input logic bl,
                                input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sb,
                                input logic [19:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.st = st; v.bl = bl; v.op = op; v.fn = fn; v.sb = sb; v.exp = e;
        return v;
    endfunction

    logic [5:0] known_ops [$];
    logic [5:0] known_fns [$];

    initial begin
        rtype_map[6'b100001] = K_RD | K_RW | K_ADD | K_UNS;
        rtype_map[6'b100011] = K_RD | K_RW | K_SUB | K_UNS;
        rtype_map[6'b100100] = K_RD | K_RW | K_AND;
        rtype_map[6'b100101] = K_RD | K_RW | K_OR;
        rtype_map[6'b100110] = K_RD | K_RW | K_XOR;
        rtype_map[6'b101010] = K_RD | K_RW | K_SUB | K_BOOL;
        rtype_map[6'b101011] = K_RD | K_RW | K_SUB | K_UNS | K_BOOL;
        rtype_map[6'b000000] = K_RD | K_RW | K_AS | K_SA | K_SL;
        rtype_map[6'b000010] = K_RD | K_RW | K_AS | K_SA | K_SR;
        rtype_map[6'b000011] = K_RD | K_RW | K_AS | K_SA | K_SR | K_ARI;
        rtype_map[6'b000100] = K_RD | K_RW | K_SL;
        rtype_map[6'b000110] = K_RD | K_RW | K_SR;
        rtype_map[6'b000111] = K_RD | K_RW | K_SR | K_ARI;
        rtype_map[6'b011000] = K_MUL;
        rtype_map[6'b011001] = K_MUL | K_UNS;
        rtype_map[6'b011010] = K_DIV;
        rtype_map[6'b011011] = K_DIV | K_UNS;
        rtype_map[6'b010000] = K_RD | K_RW;
        rtype_map[6'b010010] = K_RD | K_RW;
        rtype_map[6'b010001] = '0;
        rtype_map[6'b010011] = '0;
        rtype_map[6'b001000] = '0;
        rtype_map[6'b001001] = K_RD;
        for (int o = 1; o <= 7; o++) itype_map[6'(o)] = (o == 2 || o == 3) ? 20'h0 : (K_AS | K_SUB);
        itype_map[6'b001001] = K_AS | K_RW | K_ADD | K_UNS;
        itype_map[6'b001010] = K_AS | K_RW | K_SUB | K_BOOL;
        itype_map[6'b001011] = K_AS | K_RW | K_SUB | K_UNS | K_BOOL;
        itype_map[6'b001100] = K_AS | K_RW | K_AND;
        itype_map[6'b001101] = K_AS | K_RW | K_OR;
        itype_map[6'b001110] = K_AS | K_RW | K_XOR;
        itype_map[6'b001111] = K_AS | K_RW | K_SL;
        itype_map[6'b100011] = K_MR | K_M2R | K_AS | K_RW | K_ADD;
        itype_map[6'b101011] = K_MW | K_AS | K_ADD;
        known_ops.push_back(6'd0);
        foreach (itype_map[k]) known_ops.push_back(k);
        foreach (rtype_map[k]) known_fns.push_back(k);

        vecs.push_back(mk("addu",        0, 1, 0, 6'b000000, 6'b100001, 5'd0,  K_RD | K_RW | K_ADD | K_UNS));
        vecs.push_back(mk("sra",         0, 1, 0, 6'b000000, 6'b000011, 5'd0,  K_RD | K_RW | K_AS | K_SA | K_SR | K_ARI));
        vecs.push_back(mk("beq_link1",   0, 1, 1, 6'b000100, 6'b000000, 5'd0,  K_AS | K_SUB | K_RW | K_R31));
        vecs.push_back(mk("beq_link0",   0, 1, 0, 6'b000100, 6'b000000, 5'd0,  K_AS | K_SUB));
        vecs.push_back(mk("lw_exec",     0, 1, 0, 6'b100011, 6'b000000, 5'd0,  K_MR | K_M2R | K_AS | K_RW | K_ADD));
        vecs.push_back(mk("lw_fetch",    0, 0, 0, 6'b100011, 6'b000000, 5'd0,  K_M2R | K_AS | K_ADD));
        vecs.push_back(mk("sw",          0, 1, 0, 6'b101011, 6'b000000, 5'd0,  K_MW | K_AS | K_ADD));
        vecs.push_back(mk("bad_opcode",  0, 1, 1, 6'b111111, 6'b100001, 5'd0,  20'h0));
        vecs.push_back(mk("bad_funct",   0, 1, 1, 6'b000000, 6'b111111, 5'd0,  20'h0));
        vecs.push_back(mk("regimm_link", 0, 1, 1, 6'b000001, 6'b000000, 5'd17, K_AS | K_SUB | K_RW | K_R31));
        vecs.push_back(mk("jal_fetch",   0, 0, 1, 6'b000011, 6'b000000, 5'd0,  K_R31));
        vecs.push_back(mk("jalr_link",   0, 1, 1, 6'b000000, 6'b001001, 5'd0,  K_RD | K_RW | K_R31));
        vecs.push_back(mk("jr_nolink",   0, 1, 0, 6'b000000, 6'b001000, 5'd0,  20'h0));
        vecs.push_back(mk("mthi",        0, 1, 1, 6'b000000, 6'b010001, 5'd0,  20'h0));
        vecs.push_back(mk("multu",       0, 1, 0, 6'b000000, 6'b011001, 5'd0,  K_MUL | K_UNS));
        vecs.push_back(mk("divu",        0, 1, 0, 6'b000000, 6'b011011, 5'd0,  K_DIV | K_UNS));
        vecs.push_back(mk("sltiu",       0, 1, 0, 6'b001011, 6'b000000, 5'd0,  K_AS | K_RW | K_SUB | K_UNS | K_BOOL));
        vecs.push_back(mk("lui",         0, 1, 0, 6'b001111, 6'b000000, 5'd0,  K_AS | K_RW | K_SL));
        vecs.push_back(mk("addu_blink",  0, 1, 1, 6'b000000, 6'b100001, 5'd0,  K_RD | K_RW | K_ADD | K_UNS));
        vecs.push_back(mk("reset_addu",  1, 1, 1, 6'b000000, 6'b100001, 5'd0,  20'h0));

        drive(1, 1, 1, 6'b100011, 6'd0, 5'd0);
        #3;
        check("reset_state", outs, 20'h0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #2;
            drive(vecs[i].rst, vecs[i].st, vecs[i].bl, vecs[i].op, vecs[i].fn, vecs[i].sb);
            #1;
            check(vecs[i].name, outs, vecs[i].exp);
        end

        // Reset acts immediately and releases without any clock edge.
        @(posedge clk);
        #2;
        drive(0, 1, 0, 6'b101011, 6'd0, 5'd0);
        #1;
        check("sw_before_reset", outs, K_MW | K_AS | K_ADD);
        reset = 1'b1;
        #1;
        check("sw_reset_immediate", outs, 20'h0);
        reset = 1'b0;
        #1;
        check("sw_reset_release", outs, K_MW | K_AS | K_ADD);

        // Randomized stimulus, biased toward listed encodings.
        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            @(posedge clk);
            #2;
            op = ($urandom_range(3) == 0) ? 6'($urandom) : known_ops[$urandom_range(known_ops.size() - 1)];
            fn = ($urandom_range(3) == 0) ? 6'($urandom) : known_fns[$urandom_range(known_fns.size() - 1)];
            drive(($urandom_range(15) == 0), 1'($urandom), 1'($urandom), op, fn, 5'($urandom));
            #1;
            check($sformatf("rand%0d_op%02h_fn%02h", n, op, fn), outs, model(reset, state, b_link, op, fn));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
